op_stack_ctrl: RTL and testbench



---
 rtl/op_stack_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_op_stack_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/op_stack_ctrl.sv
// Operator-stack controller for shunting-yard infix-to-postfix conversion.
// Drives the external precedence comparator and emits a postfix token stream.
module op_stack_ctrl #(
   parameter  int unsigned DATA_W = 32,
   parameter  int unsigned DEPTH  = 16,
   localparam int unsigned CO_N   = 4
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_num,
   input  logic [DATA_W-1:0] in_data,
   output logic [CO_N-1:0]   prec_a,
   output logic [CO_N-1:0]   prec_b,
   input  logic              prec_lle_rlt,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_num,
   output logic [DATA_W-1:0] out_data,
   output logic              error,
   output logic [1:0]        err_code
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [CO_N-1:0] CO_OK = 4'd0;
   localparam logic [CO_N-1:0] CO_AD = 4'd1;
   localparam logic [CO_N-1:0] CO_SB = 4'd2;
   localparam logic [CO_N-1:0] CO_MU = 4'd3;
   localparam logic [CO_N-1:0] CO_DI = 4'd4;
   localparam logic [CO_N-1:0] CO_LP = 4'd5;
   localparam logic [CO_N-1:0] CO_RP = 4'd6;
   localparam logic [CO_N-1:0] CO_PS = 4'd7;
   localparam logic [CO_N-1:0] CO_NS = 4'd8;

   localparam logic [2:0] S_IN  = 3'd0;
   localparam logic [2:0] S_CMP = 3'd1;
   localparam logic [2:0] S_RP  = 3'd2;
   localparam logic [2:0] S_END = 3'd3;
   localparam logic [2:0] S_ERR = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [CW-1:0]     count_q, count_d;
   logic [CO_N-1:0]   stack_q [DEPTH];
   logic [CO_N-1:0]   stack_d [DEPTH];
   logic [CO_N-1:0]   hold_q, hold_d;
   logic              out_valid_q, out_valid_d;
   logic              out_num_q, out_num_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [1:0]        err_code_q, err_code_d;

   logic              slot_free;
   logic              accept;
   logic              empty;
   logic              full;
   logic              top_is_lp;
   logic [CO_N-1:0]   op_in;
   logic [CO_N-1:0]   top;
   logic [IW-1:0]     top_idx;
   logic [IW-1:0]     wr_idx;
   logic              push_en;
   logic [CO_N-1:0]   push_val;
   logic              pop_emit;

   assign slot_free = !out_valid_q || out_ready;
   assign in_ready  = ((state_q == S_IN) || (state_q == S_ERR)) && slot_free;
   assign accept    = in_valid && in_ready;
   assign op_in     = in_data[CO_N-1:0];
   assign empty     = (count_q == '0);
   assign full      = (count_q == CW'(DEPTH));
   assign top_idx   = IW'(count_q - CW'(1));
   assign wr_idx    = IW'(count_q);
   assign top       = stack_q[top_idx];
   assign top_is_lp = !empty && (top == CO_LP);

   assign prec_a    = hold_q;
   assign prec_b    = empty ? CO_OK : top;

   assign out_valid = out_valid_q;
   assign out_num   = out_num_q;
   assign out_data  = out_data_q;
   assign error     = (state_q == S_ERR);
   assign err_code  = err_code_q;

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      stack_d     = stack_q;
      hold_d      = hold_q;
      out_valid_d = out_valid_q && !out_ready;
      out_num_d   = out_num_q;
      out_data_d  = out_data_q;
      err_code_d  = err_code_q;
      push_en     = 1'b0;
      push_val    = CO_OK;
      pop_emit    = 1'b0;

      case (state_q)
         S_IN: begin
            if (accept) begin
               if (in_num) begin
                  out_valid_d = 1'b1;
                  out_num_d   = 1'b1;
                  out_data_d  = in_data;
               end else begin
                  case (op_in)
                     CO_LP, CO_PS, CO_NS: begin
                        push_en  = 1'b1;
                        push_val = op_in;
                     end
                     CO_AD, CO_SB, CO_MU, CO_DI: begin
                        hold_d  = op_in;
                        state_d = S_CMP;
                     end
                     CO_RP:   state_d = S_RP;
                     CO_OK:   state_d = S_END;
                     default: begin
                        state_d    = S_ERR;
                        err_code_d = 2'd3;
                     end
                  endcase
               end
            end
         end

         // An open paren never reduces, even if the comparator claims otherwise.
         S_CMP: begin
            if (empty || !prec_lle_rlt || top_is_lp) begin
               push_en  = 1'b1;
               push_val = hold_q;
               state_d  = S_IN;
            end else if (slot_free) begin
               pop_emit = 1'b1;
            end
         end

         S_RP: begin
            if (empty) begin
               state_d    = S_ERR;
               err_code_d = 2'd1;
            end else if (top_is_lp) begin
               count_d = count_q - CW'(1);
               state_d = S_IN;
            end else if (slot_free) begin
               pop_emit = 1'b1;
            end
         end

         S_END: begin
            if (top_is_lp) begin
               state_d    = S_ERR;
               err_code_d = 2'd1;
            end else if (!empty) begin
               if (slot_free) pop_emit = 1'b1;
            end else if (slot_free) begin
               out_valid_d = 1'b1;
               out_num_d   = 1'b0;
               out_data_d  = DATA_W'(CO_OK);
               state_d     = S_IN;
            end
         end

         S_ERR: begin
            if (accept && !in_num && (op_in == CO_OK)) begin
               count_d    = '0;
               err_code_d = 2'd0;
               state_d    = S_IN;
            end
         end

         default: begin
            state_d = S_IN;
            count_d = '0;
         end
      endcase

      // Overflow overrides whatever next state the push site chose.
      if (push_en) begin
         if (full) begin
            state_d    = S_ERR;
            err_code_d = 2'd2;
         end else begin
            stack_d[wr_idx] = push_val;
            count_d         = count_q + CW'(1);
         end
      end

      if (pop_emit) begin
         out_valid_d = 1'b1;
         out_num_d   = 1'b0;
         out_data_d  = DATA_W'(top);
         count_d     = count_q - CW'(1);
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q     <= S_IN;
         count_q     <= '0;
         hold_q      <= CO_OK;
         out_valid_q <= 1'b0;
         out_num_q   <= 1'b0;
         out_data_q  <= '0;
         err_code_q  <= 2'd0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         hold_q      <= hold_d;
         out_valid_q <= out_valid_d;
         out_num_q   <= out_num_d;
         out_data_q  <= out_data_d;
         err_code_q  <= err_code_d;
      end
   end

   always_ff @(posedge Clock) begin
      stack_q <= stack_d;
   end

endmodule

// File: tb/tb_op_stack_ctrl.sv
// Self-checking bench for op_stack_ctrl: directed test-plan expressions plus
// random token streams scored against a queue-based shunting-yard model.
module tb_op_stack_ctrl;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned DEPTH  = 16;

   localparam logic [3:0] CO_OK = 4'd0;
   localparam logic [3:0] CO_AD = 4'd1;
   localparam logic [3:0] CO_SB = 4'd2;
   localparam logic [3:0] CO_MU = 4'd3;
   localparam logic [3:0] CO_DI = 4'd4;
   localparam logic [3:0] CO_LP = 4'd5;
   localparam logic [3:0] CO_RP = 4'd6;
   localparam logic [3:0] CO_PS = 4'd7;
   localparam logic [3:0] CO_NS = 4'd8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic              in_num = 1'b0;
   logic [DATA_W-1:0] in_data = '0;
   logic [3:0]        prec_a;
   logic [3:0]        prec_b;
   logic              prec_lle_rlt;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic              out_num;
   logic [DATA_W-1:0] out_data;
   logic              error;
   logic [1:0]        err_code;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [DATA_W:0] exp_q[$];
   logic [3:0]      mstk[$];
   logic            merr  = 1'b0;
   logic [1:0]      mcode = 2'd0;

   int          rdy_mode = 0;
   int          pat_i    = 0;
   logic [3:0]  rdy_pat  = 4'b1001;
   logic        stall_prev = 1'b0;
   logic [DATA_W:0] prev_tok = '0;
   logic [DATA_W:0] mon_exp;

   always #5 clk = ~clk;

   op_stack_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .Clock(clk), .Reset(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_num(in_num), .in_data(in_data),
      .prec_a(prec_a), .prec_b(prec_b), .prec_lle_rlt(prec_lle_rlt),
      .out_valid(out_valid), .out_ready(out_ready), .out_num(out_num), .out_data(out_data),
      .error(error), .err_code(err_code)
   );

   function automatic int prio(input logic [3:0] op);
      case (op)
         CO_AD, CO_SB: return 1;
         CO_PS, CO_NS: return 2;
         CO_MU, CO_DI: return 3;
         default:      return 0;
      endcase
   endfunction

   // Comparator stand-in: pop when the stacked op binds at least as tightly.
   always_comb begin
      if (prec_b == CO_OK || prec_b == CO_LP) prec_lle_rlt = 1'b0;
      else prec_lle_rlt = (prio(prec_b) >= prio(prec_a));
   end

   // Output side: choose out_ready for the coming edge, then score the handshake.
   always @(negedge clk) begin
      case (rdy_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'($urandom_range(0, 1));
         default: begin
            out_ready = rdy_pat[pat_i];
            pat_i = (pat_i + 1) % 4;
         end
      endcase
      if (stall_prev && !rst) begin
         checks++;
         assert (out_valid === 1'b1 && {out_num, out_data} === prev_tok)
         else begin
            errors++;
            $error("FAIL hold_stable got v=%0b tok=%h exp v=1 tok=%h", out_valid, {out_num, out_data}, prev_tok);
         end
      end
      if (out_valid && out_ready && !rst) begin
         checks++;
         assert (exp_q.size() != 0)
         else begin
            errors++;
            $error("FAIL unexpected_out got tok=%h exp none", {out_num, out_data});
         end
         if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            checks++;
            assert ({out_num, out_data} === mon_exp)
            else begin
               errors++;
               $error("FAIL out_tok got %h exp %h", {out_num, out_data}, mon_exp);
            end
         end
      end
      stall_prev = out_valid && !out_ready && !rst;
      prev_tok   = {out_num, out_data};
   end

   task automatic emit(input logic [3:0] op);
      exp_q.push_back({1'b0, DATA_W'(op)});
   endtask

   task automatic set_err(input logic [1:0] c);
      merr  = 1'b1;
      mcode = c;
   endtask

   task automatic push_op(input logic [3:0] op);
      if (mstk.size() == DEPTH) set_err(2'd2);
      else mstk.push_back(op);
   endtask

   // Shunting-yard reference, applied to each accepted token.
   task automatic model_tok(input logic num, input logic [DATA_W-1:0] d);
      logic [3:0] op;
      op = d[3:0];
      if (merr) begin
         if (!num && op == CO_OK) begin
            mstk.delete();
            merr  = 1'b0;
            mcode = 2'd0;
         end
      end else if (num) begin
         exp_q.push_back({1'b1, d});
      end else begin
         case (op)
            CO_LP, CO_PS, CO_NS: push_op(op);
            CO_AD, CO_SB, CO_MU, CO_DI: begin
               while (mstk.size() > 0 && mstk[$] != CO_LP && prio(mstk[$]) >= prio(op))
                  emit(mstk.pop_back());
               push_op(op);
            end
            CO_RP: begin
               while (mstk.size() > 0 && mstk[$] != CO_LP) emit(mstk.pop_back());
               if (mstk.size() == 0) set_err(2'd1);
               else void'(mstk.pop_back());
            end
            CO_OK: begin
               while (mstk.size() > 0 && mstk[$] != CO_LP) emit(mstk.pop_back());
               if (mstk.size() > 0) set_err(2'd1);
               else emit(CO_OK);
            end
            default: set_err(2'd3);
         endcase
      end
   endtask

   task automatic send(input logic num, input logic [DATA_W-1:0] d);
      int n = 0;
      logic done = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      in_num   = num;
      in_data  = d;
      while (!done && n < 200) begin
         #2;
         if (in_ready) begin
            @(posedge clk);
            done = 1'b1;
         end else begin
            n++;
            @(negedge clk);
         end
      end
      #1;
      in_valid = 1'b0;
      checks++;
      assert (done === 1'b1)
      else begin
         errors++;
         $error("FAIL accept_timeout got ready=0 exp ready=1 tok=%h", {num, d});
      end
      if (done) model_tok(num, d);
   endtask

   task automatic n_(input int v);
      send(1'b1, DATA_W'(v));
   endtask

   task automatic o_(input logic [3:0] c);
      send(1'b0, DATA_W'(c));
   endtask

   function automatic logic [DATA_W-1:0] opw(input logic [3:0] c);
      logic [DATA_W-1:0] w;
      w = $urandom();
      w[3:0] = c;
      return w;
   endfunction

   task automatic drain_check(input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      repeat (6) @(negedge clk);
      #2;
      checks++;
      assert (exp_q.size() == 0)
      else begin errors++; $error("FAIL %s_drain got %0d pending exp 0", tag, exp_q.size()); end
      checks++;
      assert (error === merr)
      else begin errors++; $error("FAIL %s_error got %0b exp %0b", tag, error, merr); end
      checks++;
      assert (err_code === mcode)
      else begin errors++; $error("FAIL %s_err_code got %0d exp %0d", tag, err_code, mcode); end
      checks++;
      assert (int'(dut.count_q) === mstk.size())
      else begin errors++; $error("FAIL %s_count got %0d exp %0d", tag, dut.count_q, mstk.size()); end
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      checks++;
      assert ({out_valid, out_num, out_data, error, err_code} === '0)
      else begin errors++; $error("FAIL reset_outs got v=%0b n=%0b d=%h e=%0b c=%0d exp all 0", out_valid, out_num, out_data, error, err_code); end
      checks++;
      assert (in_ready === 1'b1)
      else begin errors++; $error("FAIL reset_in_ready got %0b exp 1", in_ready); end
      checks++;
      assert (prec_a === CO_OK && prec_b === CO_OK)
      else begin errors++; $error("FAIL reset_prec got a=%0d b=%0d exp 0 0", prec_a, prec_b); end

      // 1 + 2 * 3
      rdy_mode = 0;
      n_(1); o_(CO_AD); n_(2); o_(CO_MU); n_(3); o_(CO_OK);
      drain_check("prec");
      // ( 1 + 2 ) * 3
      o_(CO_LP); n_(1); o_(CO_AD); n_(2); o_(CO_RP); o_(CO_MU); n_(3); o_(CO_OK);
      drain_check("paren");
      // 8 - 3 - 2
      n_(8); o_(CO_SB); n_(3); o_(CO_SB); n_(2); o_(CO_OK);
      drain_check("leftassoc");
      // NS 4 * 5 under 1-0-0-1 backpressure
      rdy_mode = 2;
      o_(CO_NS); n_(4); o_(CO_MU); n_(5); o_(CO_OK);
      drain_check("unary");

      // 1 ) -> paren error, OK recovers, then 2 OK
      rdy_mode = 0;
      n_(1); o_(CO_RP);
      drain_check("rp_err");
      o_(CO_OK);
      drain_check("rp_clear");
      n_(2); o_(CO_OK);
      drain_check("after_clear");

      // Overflow on the 17th open paren; stack stays full
      for (int i = 0; i < 16; i++) o_(CO_LP);
      drain_check("full");
      o_(CO_LP);
      drain_check("overflow");
      o_(CO_OK);
      drain_check("ovf_clear");

      // Bad opcode
      o_(4'd12);
      drain_check("badop");
      o_(CO_OK);
      drain_check("badop_clear");

      // Reset while in S_CMP with three ops stacked
      o_(CO_LP); o_(CO_LP); o_(CO_LP); o_(CO_AD);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      mstk.delete();
      exp_q.delete();
      merr  = 1'b0;
      mcode = 2'd0;
      checks++;
      assert (out_valid === 1'b0 && in_ready === 1'b1)
      else begin errors++; $error("FAIL midreset got v=%0b rdy=%0b exp v=0 rdy=1", out_valid, in_ready); end
      checks++;
      assert (int'(dut.count_q) === 0)
      else begin errors++; $error("FAIL midreset_count got %0d exp 0", dut.count_q); end
      n_(7); o_(CO_OK);
      drain_check("post_reset");

      // Random token streams with random backpressure
      rdy_mode = 1;
      for (int b = 0; b < 10; b++) begin
         for (int t = 0; t < 30; t++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 40)      send(1'b1, $urandom());
            else if (r < 52) send(1'b0, opw(CO_LP));
            else if (r < 62) send(1'b0, opw(CO_RP));
            else if (r < 84) send(1'b0, opw(4'($urandom_range(1, 4))));
            else if (r < 92) send(1'b0, opw($urandom_range(0, 1) == 0 ? CO_PS : CO_NS));
            else if (r < 95) send(1'b0, opw(4'($urandom_range(9, 15))));
            else             send(1'b0, opw(CO_OK));
         end
         o_(CO_OK);
         if (merr) o_(CO_OK);
         drain_check("random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
